// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
//   Shared types and helpers for the hiscore RAM arbiter.
//   - arb_state_e : arbiter FSM states
//   - cnt_width() : bit width needed to hold a counter value 0..max_val
package hs_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_WAIT,
    S_SETTLE,
    S_GRANT,
    S_DRAIN,
    S_RELEASE
  } arb_state_e;

  // clog2(max_val+1), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hs_ram_arbiter_rd_pipe.sv
// hs_rd_pipe
//   Tracks the single outstanding RAM read. issue_i is high in the cycle the
//   read address is on the RAM port; the flag then travels RD_LAT stages so
//   rvalid_o lines up with the RAM's read data.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     issue_i     read address presented to the RAM this cycle
//     rvalid_o    RAM read data valid this cycle
//     busy_o      read still in flight (excludes the data-return cycle)
module hs_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  output logic rvalid_o,
  output logic busy_o
);

  logic [RD_LAT-1:0] sr_q;

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q[0] <= 1'b0;
        else       sr_q[0] <= issue_i;
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q[gi] <= 1'b0;
        else       sr_q[gi] <= sr_q[gi-1];
      end
    end
  end

  assign rvalid_o = sr_q[RD_LAT-1];

  // The return cycle itself is not busy, so a new read may be accepted
  // alongside the data of the previous one.
  always_comb begin
    busy_o = issue_i;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      busy_o = busy_o | sr_q[k];
    end
  end

endmodule

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
//   Lends the game work-RAM port to the hiscore engine: pauses the CPU, waits
//   for halt acknowledge plus a settle interval, grants single-beat access,
//   then hands the port back before un-pausing the CPU.
//   Ports:
//     clk, reset                 clock / asynchronous active-high reset
//     hs_req/hs_grant            session request / port owned by engine
//     hs_valid/hs_ready/hs_we    beat handshake and direction
//     hs_addr/hs_wdata           beat address / write data
//     hs_rdata/hs_rvalid         read data with one-cycle valid pulse
//     hs_err                     sticky halt-acknowledge timeout
//     pause_cpu/cpu_halted       CPU pause request / halt acknowledge
//     ram_access                 RAM mux select (1 = arbiter owns port)
//     ram_addr/ram_wdata/ram_we  RAM port, zero whenever ram_access=0
//     ram_rdata                  RAM read data
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hs_req,
  output logic          hs_grant,
  input  logic          hs_valid,
  output logic          hs_ready,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_rvalid,
  output logic          hs_err,
  output logic          pause_cpu,
  input  logic          cpu_halted,
  output logic          ram_access,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  // One counter serves both the halt timeout (counts up) and the settle
  // interval (counts down), so size it for the larger of the two.
  localparam int unsigned CW = cnt_width((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          req_q;
  logic          pause_q, access_q, grant_q;
  logic          we_q, rd_issue_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rd_busy, rd_valid, beat_acc;

  hs_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .issue_i  (rd_issue_q),
    .rvalid_o (rd_valid),
    .busy_o   (rd_busy)
  );

  // Requiring hs_req here keeps beats from being taken once the engine has
  // started closing the session.
  assign hs_ready = (state_q == S_GRANT) && hs_req && !rd_busy;
  assign beat_acc = hs_valid && hs_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (hs_req && !req_q) err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hs_req) begin
          state_d = S_PAUSE_WAIT;
          cnt_d   = '0;
        end
      end
      S_PAUSE_WAIT: begin
        if (!hs_req) begin
          state_d = S_RELEASE;
        end else if (cpu_halted) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LAST;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        // cpu_halted is deliberately not looked at: the CPU must stay
        // halted for as long as pause_cpu is high.
        if (!hs_req)           state_d = S_RELEASE;
        else if (cnt_q == '0)  state_d = S_GRANT;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      S_GRANT: begin
        if (!hs_req && !rd_busy) state_d = S_DRAIN;
      end
      S_DRAIN:   state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the port is released one
  // cycle (RELEASE) before pause_cpu drops on the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      pause_q    <= 1'b0;
      access_q   <= 1'b0;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      rd_issue_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      req_q      <= hs_req;
      pause_q    <= (state_d != S_IDLE);
      access_q   <= (state_d == S_GRANT) || (state_d == S_DRAIN);
      grant_q    <= (state_d == S_GRANT);
      we_q       <= beat_acc && hs_we;
      rd_issue_q <= beat_acc && !hs_we;
      if (beat_acc) begin
        addr_q <= hs_addr;
        if (hs_we) wdata_q <= hs_wdata;
      end
    end
  end

  assign hs_grant   = grant_q;
  assign hs_err     = err_q;
  assign pause_cpu  = pause_q;
  assign ram_access = access_q;
  assign ram_addr   = access_q ? addr_q  : '0;
  assign ram_wdata  = access_q ? wdata_q : '0;
  assign ram_we     = access_q && we_q;
  assign hs_rvalid  = rd_valid;
  assign hs_rdata   = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: three instances with RD_LAT = 1, 2, 3 (SETTLE=4,
// TIMEOUT=16), each with its own RAM model. One instance is exercised at a
// time (cur); a scoreboard queues expected RAM writes and read returns.
module tb_hs_ram_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int SET = 4;
  localparam int TMO = 16;
  localparam int ND  = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          hs_req[ND], hs_valid[ND], hs_we[ND], cpu_halted[ND];
  logic [AW-1:0] hs_addr[ND];
  logic [DW-1:0] hs_wdata[ND];
  logic          hs_grant[ND], hs_ready[ND], hs_rvalid[ND], hs_err[ND];
  logic          pause_cpu[ND], ram_access[ND], ram_we[ND];
  logic [DW-1:0] hs_rdata[ND], ram_wdata[ND], ram_rdata[ND];
  logic [AW-1:0] ram_addr[ND];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    hs_ram_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(gi + 1), .SETTLE(SET), .TIMEOUT(TMO)
    ) u_dut (
      .clk(clk), .reset(reset),
      .hs_req(hs_req[gi]), .hs_grant(hs_grant[gi]),
      .hs_valid(hs_valid[gi]), .hs_ready(hs_ready[gi]), .hs_we(hs_we[gi]),
      .hs_addr(hs_addr[gi]), .hs_wdata(hs_wdata[gi]),
      .hs_rdata(hs_rdata[gi]), .hs_rvalid(hs_rvalid[gi]), .hs_err(hs_err[gi]),
      .pause_cpu(pause_cpu[gi]), .cpu_halted(cpu_halted[gi]),
      .ram_access(ram_access[gi]), .ram_addr(ram_addr[gi]),
      .ram_wdata(ram_wdata[gi]), .ram_we(ram_we[gi]), .ram_rdata(ram_rdata[gi])
    );

    // RAM with gi+1 cycles of read latency. Unwritten locations read 0,
    // except 0x0F0 which holds 0x3C.
    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] vld;
    logic [DW-1:0]     rpipe [0:gi];
    always @(posedge clk) begin
      if (reset) vld <= '0;
      else if (ram_we[gi]) begin
        mem[ram_addr[gi]] <= ram_wdata[gi];
        vld[ram_addr[gi]] <= 1'b1;
      end
      rpipe[0] <= vld[ram_addr[gi]] ? mem[ram_addr[gi]]
                : ((ram_addr[gi] == 12'h0F0) ? 8'h3C : 8'h00);
      for (int k = 1; k <= gi; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_rdata[gi] = rpipe[gi];
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   cur      = 1;
  int   grant_seen = 0;
  exp_t wq[$];
  exp_t rq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs(input int i);
    return {29'd0, hs_grant[i], hs_ready[i], hs_rdata[i], hs_rvalid[i], hs_err[i],
            pause_cpu[i], ram_access[i], ram_addr[i], ram_wdata[i], ram_we[i]};
  endfunction

  // Advance to the next falling edge and run the scoreboard monitor there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (hs_grant[cur] || ram_access[cur]) grant_seen++;
      if (ram_we[cur]) begin
        check("wr_expected", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          $display("wr  dut%0d addr=%03h data=%02h cyc=%0d", cur, ram_addr[cur], ram_wdata[cur], cyc);
          check("wr_addr", ram_addr[cur], e.addr);
          check("wr_data", ram_wdata[cur], e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (hs_rvalid[cur]) begin
        check("rd_expected", rq.size() > 0, 1'b1);
        if (rq.size() > 0) begin
          e = rq.pop_front();
          $display("rd  dut%0d addr=%03h data=%02h cyc=%0d", cur, e.addr, hs_rdata[cur], cyc);
          check("rd_data", hs_rdata[cur], e.data);
          check("rd_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // Present one beat at the current falling edge; returns cycles waited.
  task automatic beat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int n);
    exp_t e;
    n = 0;
    hs_valid[cur] = 1'b1; hs_we[cur] = we; hs_addr[cur] = a; hs_wdata[cur] = d;
    while (!hs_ready[cur] && n < 20) begin tick(); n++; end
    check("beat_ready", hs_ready[cur], 1'b1);
    if (hs_ready[cur]) begin
      e.addr = a; e.data = d;
      e.cyc  = we ? cyc + 1 : cyc + 1 + (cur + 1);
      if (we) wq.push_back(e); else rq.push_back(e);
    end
    tick();
    hs_valid[cur] = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    beat(1'b0, a, d, n);
    for (int k = 0; k < cur + 1; k++) begin
      check("rd_busy", hs_ready[cur], 1'b0);
      tick();
    end
    check("rd_ready_back", hs_ready[cur], 1'b1);
    check("rd_drained", rq.size(), 0);
  endtask

  task automatic wait_pause();
    int n;
    n = 0;
    do begin tick(); n++; end while (!pause_cpu[cur] && n < 8);
    check("pause_lat", n, 1);
  endtask

  task automatic open_session(input int halt_dly);
    int n;
    hs_req[cur] = 1'b1;
    wait_pause();
    repeat (halt_dly) tick();
    cpu_halted[cur] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!hs_grant[cur] && n < 20);
    check("grant_lat", n, SET + 1);
    check("grant_access", ram_access[cur], 1'b1);
  endtask

  task automatic close_session();
    hs_req[cur] = 1'b0;
    tick();
    check("drain_grant", hs_grant[cur], 1'b0);
    check("drain_access", ram_access[cur], 1'b1);
    tick();
    check("rel_access", ram_access[cur], 1'b0);
    check("rel_pause", pause_cpu[cur], 1'b1);
    tick();
    check("idle_pause", pause_cpu[cur], 1'b0);
    cpu_halted[cur] = 1'b0;
    tick();
  endtask

  task automatic drop_and_count(input string tag);
    int n;
    hs_req[cur] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (pause_cpu[cur] && n < 8);
    check(tag, n, 2);
    cpu_halted[cur] = 1'b0;
    tick();
  endtask

  initial begin
    int n, g0;
    for (int i = 0; i < ND; i++) begin
      hs_req[i] = 1'b0; hs_valid[i] = 1'b0; hs_we[i] = 1'b0; cpu_halted[i] = 1'b0;
      hs_addr[i] = '0; hs_wdata[i] = '0;
    end
    reset = 1'b1;
    tick(); tick();
    check("rst_outs", outs(1), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_outs", outs(1), 64'd0);

    // Basic session with back-to-back writes and read-back (RD_LAT=2).
    cur = 1;
    open_session(3);
    beat(1'b1, 12'h100, 8'hA5, n); check("wr_nowait", n, 0);
    beat(1'b1, 12'h101, 8'h5A, n); check("wr_nowait", n, 0);
    beat(1'b1, 12'h102, 8'hFF, n); check("wr_nowait", n, 0);
    check("wr_drained", wq.size(), 0);
    rd(12'h101, 8'h5A);
    rd(12'h0F0, 8'h3C);
    rd(12'h102, 8'hFF);
    close_session();

    // Read latency on the RD_LAT=1 and RD_LAT=3 instances.
    for (int i = 0; i < ND; i += 2) begin
      cur = i;
      open_session(3);
      rd(12'h0F0, 8'h3C);
      close_session();
    end

    // Early drop in PAUSE_WAIT and in SETTLE.
    cur = 1;
    g0 = grant_seen;
    hs_req[cur] = 1'b1;
    wait_pause();
    tick();
    drop_and_count("drop_pw_pause");
    hs_req[cur] = 1'b1;
    wait_pause();
    cpu_halted[cur] = 1'b1;
    tick(); tick();
    drop_and_count("drop_st_pause");
    check("drop_no_grant", grant_seen - g0, 0);

    // Halt-acknowledge timeout.
    g0 = grant_seen;
    hs_req[cur] = 1'b1;
    wait_pause();
    n = 0;
    while (!hs_err[cur] && n < 40) begin tick(); n++; end
    check("tmo_cycle", n, TMO);
    hs_req[cur] = 1'b0;
    check("tmo_pause_hold", pause_cpu[cur], 1'b1);
    tick();
    check("tmo_pause_rel", pause_cpu[cur], 1'b0);
    tick(); tick();
    check("err_sticky", hs_err[cur], 1'b1);
    check("tmo_no_grant", grant_seen - g0, 0);
    hs_req[cur] = 1'b1;
    tick();
    check("err_clear", hs_err[cur], 1'b0);
    drop_and_count("tmo_abort_pause");

    // Reset one cycle after a read is accepted.
    open_session(3);
    beat(1'b0, 12'h0F0, 8'h3C, n);
    reset = 1'b1;
    #1;
    check("rst_async_outs", outs(1), 64'd0);
    rq.delete(); wq.delete();
    hs_req[cur] = 1'b0; cpu_halted[cur] = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    check("post_rst_outs", outs(1), 64'd0);
    open_session(2);
    beat(1'b1, 12'h123, 8'h77, n); check("wr_nowait", n, 0);
    rd(12'h123, 8'h77);
    close_session();

    check("final_wq", wq.size(), 0);
    check("final_rq", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
